// File: rtl/bp_update_scheduler_pkg.sv
// Shared constants for the branch predictor update scheduler: write opcodes,
// default table geometry and the sweep initialisation value.
package bp_update_scheduler_pkg;

  typedef logic [1:0] bp_op_t;

  localparam bp_op_t     BP_OP_SET     = 2'd0;
  localparam bp_op_t     BP_OP_INC     = 2'd1;
  localparam bp_op_t     BP_OP_DEC     = 2'd2;

  localparam int         BP_IDX_W      = 5;
  localparam logic [1:0] BP_INIT_VAL   = 2'b10;
  localparam int         BP_FIFO_DEPTH = 4;
  localparam int         RAM_ADR_W     = 32;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Bus between ROB commit / Ins-Fetch / predictor (master side) and the update
// scheduler (slave side).
interface bp_update_scheduler_if
  import bp_update_scheduler_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
);
  logic                 c0_en_i;
  logic [RAM_ADR_W-1:0] c0_pc_i;
  logic                 c0_abr_i;
  logic                 c1_en_i;
  logic [RAM_ADR_W-1:0] c1_pc_i;
  logic                 c1_abr_i;
  logic                 clr_i;
  logic                 stall_o;
  logic                 bp_busy_o;
  logic                 bp_we_o;
  logic [IDX_W-1:0]     bp_idx_o;
  bp_op_t               bp_op_o;
  logic [1:0]           bp_val_o;

  modport master (
    output c0_en_i, c0_pc_i, c0_abr_i, c1_en_i, c1_pc_i, c1_abr_i, clr_i,
    input  stall_o, bp_busy_o, bp_we_o, bp_idx_o, bp_op_o, bp_val_o
  );

  modport slave (
    input  c0_en_i, c0_pc_i, c0_abr_i, c1_en_i, c1_pc_i, c1_abr_i, clr_i,
    output stall_o, bp_busy_o, bp_we_o, bp_idx_o, bp_op_o, bp_val_o
  );
endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// bp_upd_fifo: in-order dual-push / single-pop queue with occupancy count and flush.
// Per-cycle drop reporting exists only when BP_SCHED_STAT_EN is defined.
module bp_upd_fifo #(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push0,
  input  logic [W-1:0]     d0,
  input  logic             push1,
  input  logic [W-1:0]     d1,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
`ifdef BP_SCHED_STAT_EN
  ,
  output logic [CNT_W-1:0] drop_num
`endif
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] free;
  logic             acc0;
  logic             acc1;
  logic             do_pop;

  assign free   = CNT_W'(DEPTH) - count;
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty && !flush;

  // Capacity is judged before this cycle's pop, so c1 is the first to go.
  always_comb begin
    // NOTE: defaults first so every path assigns both flags and no latch is inferred.
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!flush) begin
      acc0 = push0 && (free != '0);
      acc1 = push1 && (free > CNT_W'(acc0));
    end
  end

  // NOTE: storage is not reset; a slot is only read after count marks it valid.
  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr] <= d0;
    if (acc1) mem[wr_ptr + PTR_W'(acc0)] <= d1;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(acc0) + PTR_W'(acc1);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(do_pop);
    end
  end

`ifdef BP_SCHED_STAT_EN
  assign drop_num = flush ? count : CNT_W'(push0 && !acc0) + CNT_W'(push1 && !acc1);
`endif

endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences all predictor table writes: an init sweep of INIT_VAL, then queued
// commit feedback as INC/DEC. Define BP_SCHED_STAT_EN to add stat_upd_o/stat_drop_o.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int         IDX_W      = BP_IDX_W,
  parameter int         FIFO_DEPTH = BP_FIFO_DEPTH,
  parameter logic [1:0] INIT_VAL   = BP_INIT_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  bp_update_scheduler_if.slave bus
`ifdef BP_SCHED_STAT_EN
  ,
  output logic [31:0] stat_upd_o,
  output logic [31:0] stat_drop_o
`endif
);
  localparam int         ENT_W   = IDX_W + 1;
  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_idx;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  bp_op_t           op_q;
  logic [1:0]       val_q;

  logic             run_en;
  logic             flush;
  logic             push0;
  logic             push1;
  logic             pop;
  logic             fifo_empty;
  logic [ENT_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_pc_bits;

  // Feedback is only accepted in RUN; a clear request discards it.
  assign run_en = en && (state == ST_RUN);
  assign flush  = run_en && bus.clr_i;
  assign push0  = run_en && !bus.clr_i && bus.c0_en_i;
  assign push1  = run_en && !bus.clr_i && bus.c1_en_i;
  assign pop    = run_en && !bus.clr_i && !fifo_empty;

  assign unused_pc_bits = ^{bus.c0_pc_i[RAM_ADR_W-1:IDX_W+2], bus.c0_pc_i[1:0],
                            bus.c1_pc_i[RAM_ADR_W-1:IDX_W+2], bus.c1_pc_i[1:0]};

`ifdef BP_SCHED_STAT_EN
  logic [CNT_W-1:0] drop_num;
`endif

  bp_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push0    (push0),
    .d0       ({bus.c0_pc_i[IDX_W+1:2], bus.c0_abr_i}),
    .push1    (push1),
    .d1       ({bus.c1_pc_i[IDX_W+1:2], bus.c1_abr_i}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
`ifdef BP_SCHED_STAT_EN
    ,
    .drop_num (drop_num)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      op_q      <= BP_OP_SET;
      val_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (en) begin
        if (state == ST_INIT) begin
          if (bus.clr_i) begin
            sweep_idx <= '0;
          end else begin
            we_q      <= 1'b1;
            idx_q     <= sweep_idx;
            op_q      <= BP_OP_SET;
            val_q     <= INIT_VAL;
            sweep_idx <= sweep_idx + IDX_W'(1);
            if (&sweep_idx) state <= ST_RUN;
          end
        end else if (bus.clr_i) begin
          state     <= ST_INIT;
          sweep_idx <= '0;
        end else if (!fifo_empty) begin
          we_q  <= 1'b1;
          idx_q <= fifo_head[ENT_W-1:1];
          op_q  <= fifo_head[0] ? BP_OP_INC : BP_OP_DEC;
          val_q <= '0;
        end
      end
    end
  end

  // Busy also covers the cycle the last sweep write is on the bus.
  assign bus.bp_busy_o = (state == ST_INIT) || (we_q && (op_q == BP_OP_SET));
  assign bus.stall_o   = (state == ST_INIT) ||
                         ((CNT_W'(FIFO_DEPTH) - fifo_count) < CNT_W'(2));
  assign bus.bp_we_o   = we_q;
  assign bus.bp_idx_o  = idx_q;
  assign bus.bp_op_o   = op_q;
  assign bus.bp_val_o  = val_q;

`ifdef BP_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_upd_o  <= '0;
      stat_drop_o <= '0;
    end else begin
      if (pop) stat_upd_o <= stat_upd_o + 32'd1;
      stat_drop_o <= stat_drop_o + 32'(drop_num);
    end
  end
`endif

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
Sequences all writes into the 2-bit-counter branch predictor table. It owns two jobs:
- A post-reset / on-demand initialisation sweep that writes "weakly taken" into every entry, one entry per cycle.
- Arbitration of branch-outcome feedback from a dual-commit ROB (two requesters) into the predictor's single write port, through a small in-order FIFO.

It sits between ROB commit and the branch predictor. It tells Ins-Fetch when predictions are invalid.

Parameters:
IDX_W, 5, predictor index width; table holds 2^IDX_W entries; index = pc[IDX_W+1:2]
FIFO_DEPTH, 4, feedback queue entries; power of two, >= 2
INIT_VAL, 2'b10, counter value written during the sweep (weakly taken)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets the block)
en  in  1  global ready; when 0, all state holds, inputs are ignored, bp_we_o=0
c0_en_i  in  1  commit port 0 carries a resolved branch (older of the pair)
c0_pc_i  in  RAM_ADR_W  pc of that branch
c0_abr_i  in  1  actually taken
c1_en_i  in  1  commit port 1 carries a resolved branch (younger)
c1_pc_i  in  RAM_ADR_W  pc of that branch
c1_abr_i  in  1  actually taken
clr_i  in  1  request table re-initialisation
stall_o  out  1  ROB must not present feedback this cycle
bp_busy_o  out  1  sweep in progress; IF must treat every prediction as not-taken
bp_we_o  out  1  predictor write strobe (registered)
bp_idx_o  out  IDX_W  entry to write
bp_op_o  out  2  BP_OP_SET / BP_OP_INC / BP_OP_DEC
bp_val_o  out  2  value for BP_OP_SET; 0 otherwise

Behaviour:
- FSM has two states, INIT and RUN.
- Reset: state=INIT, sweep idx=0, FIFO empty, bp_we_o=0, bp_idx_o=0, bp_op_o=0, bp_val_o=0, bp_busy_o=1, stall_o=1.
- INIT, each en cycle:
  - register bp_we_o=1, bp_op_o=SET, bp_val_o=INIT_VAL, bp_idx_o=idx; then idx+1.
  - After the write of idx=2^IDX_W-1, go to RUN. The sweep takes exactly 2^IDX_W enabled cycles.
  - Feedback is dropped. bp_busy_o=1, stall_o=1.
- RUN:
  - bp_busy_o=0.
  - stall_o = (free slots < 2). This is combinational from the registered count, so a 1-slot-free FIFO stalls.
  - Push: c0 is enqueued before c1 in the same cycle. Either port alone uses one slot. Entry = {idx=pc[IDX_W+1:2], taken}.
  - Pop: when the FIFO is non-empty, one entry per enabled cycle. Next cycle drives bp_we_o=1, bp_idx_o=entry.idx, bp_op_o=INC if taken else DEC, bp_val_o=0.
  - Otherwise bp_we_o=0.
  - Push and pop may occur in the same cycle; count changes by (pushes - 1).
  - Latency: a request sampled at posedge N produces bp_we_o high after posedge N+1 when the FIFO was empty, with no bypass.
  - The predictor saturates; this block never inspects counter values.
- Overflow: a push while stall_o=1 is a protocol violation. Entries beyond capacity are discarded, c1 first, and FIFO contents are never corrupted.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is a separate log2(FIFO_DEPTH)+1 bit counter.
- clr_i (en=1):
  - In RUN: flush the FIFO (pending updates are lost), state=INIT, idx=0. Same-cycle pushes are dropped, and any same-cycle pop is suppressed (bp_we_o=0 next cycle).
  - In INIT: restart with idx=0.
- Reset mid-sweep or mid-drain returns to the reset state regardless of en.
- en=0: FSM, idx, FIFO and count hold; bp_we_o=0 next cycle; other outputs hold.

Optional Feature:
BP_SCHED_STAT_EN
- Defined: adds outputs stat_upd_o[31:0] (predictor INC/DEC writes issued) and stat_drop_o[31:0] (feedback entries discarded by overflow or clr_i flush). Both reset to 0, wrap at 2^32, and do not count sweep writes.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- head.v: BP_OP_SET=2'd0, BP_OP_INC=2'd1, BP_OP_DEC=2'd2, BP_IDX_W default, BP_INIT_VAL.
- Sub-module bp_upd_fifo: parametric dual-push / single-pop FIFO with count, flush and drop reporting.
- The FSM and output register stay in bp_update_scheduler.

Test Plan:
- Reset, en=1: bp_we_o=1 for exactly 32 cycles with idx 0..31, op=SET, val=2'b10, bp_busy_o=1; then bp_busy_o=0 and stall_o=0.
- RUN, same cycle c0 pc=0x0000_0010 taken, c1 pc=0x0000_0084 not-taken: bp_we_o idx=4 op=INC at N+1, then idx=1 op=DEC at N+2.
- Pairs pushed for 3 consecutive cycles: stall_o rises when free<2; a forced push under stall drops c1 and stat_drop_o increments; the remaining order is preserved.
- clr_i at sweep idx=17: next write idx=0; 32 further writes occur before RUN.
- clr_i with 3 queued entries: no INC/DEC emitted; sweep starts next cycle; stat_drop_o += 3.
- en=0 for 5 cycles mid-drain: bp_we_o=0 and queue unchanged; on resume, drain continues in original order.
